sc_car_move_controller: RTL and testbench

- FSM that sequences the player-car position shift register (8-bit one-hot lane register: clear, load-to-centre, shift left/right).
- Turns raw active-low left/right/start buttons and a crash flag into one-cycle register commands.
- Enforces a move cooldown and reports lane-limit hits.
- Sits between the button inputs and the car register. Game-level logic reads its state output.

---
 rtl/sc_car_move_controller_pkg.sv | 21 ++
 rtl/sc_car_move_controller_if.sv | 31 +++
 rtl/sc_button_sync_edge.sv | 28 ++
 rtl/sc_car_move_controller.sv | 118 +++++++++++
 tb/tb_sc_car_move_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_car_move_controller_pkg.sv
// rtl/sc_car_move_controller_pkg.sv - shared state codes, shift codes and lane constants for the car move controller
package sc_car_move_controller_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN      = 3'd2,
        MOVE     = 3'd3,
        COOLDOWN = 3'd4,
        CRASHED  = 3'd5
    } car_state_t;

    localparam logic [1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    localparam logic [7:0] LANE_LEFT_LIMIT  = 8'b01000000;
    localparam logic [7:0] LANE_RIGHT_LIMIT = 8'b00000010;
    localparam logic [7:0] LANE_CENTRE      = 8'b00010000;

endpackage

// File: rtl/sc_car_move_controller_if.sv
// rtl/sc_car_move_controller_if.sv - button, crash, car-register command and status bundle of the car move controller
interface sc_car_move_controller_if #(
    parameter int POS_WIDTH = 8
);
    logic                 SC_CARCTRL_start_InLow;
    logic                 SC_CARCTRL_left_InLow;
    logic                 SC_CARCTRL_right_InLow;
    logic                 SC_CARCTRL_crash_InHigh;
    logic [POS_WIDTH-1:0] SC_CARCTRL_position_InBus;
    logic                 SC_CARCTRL_clear_OutLow;
    logic                 SC_CARCTRL_load_OutLow;
    logic [1:0]           SC_CARCTRL_shift_OutBus;
    logic                 SC_CARCTRL_limit_OutHigh;
    logic [2:0]           SC_CARCTRL_state_OutBus;

    // master drives buttons/crash/position; slave is the controller
    modport master (
        output SC_CARCTRL_start_InLow, SC_CARCTRL_left_InLow, SC_CARCTRL_right_InLow,
               SC_CARCTRL_crash_InHigh, SC_CARCTRL_position_InBus,
        input  SC_CARCTRL_clear_OutLow, SC_CARCTRL_load_OutLow, SC_CARCTRL_shift_OutBus,
               SC_CARCTRL_limit_OutHigh, SC_CARCTRL_state_OutBus
    );

    modport slave (
        input  SC_CARCTRL_start_InLow, SC_CARCTRL_left_InLow, SC_CARCTRL_right_InLow,
               SC_CARCTRL_crash_InHigh, SC_CARCTRL_position_InBus,
        output SC_CARCTRL_clear_OutLow, SC_CARCTRL_load_OutLow, SC_CARCTRL_shift_OutBus,
               SC_CARCTRL_limit_OutHigh, SC_CARCTRL_state_OutBus
    );

endinterface

// File: rtl/sc_button_sync_edge.sv
// rtl/sc_button_sync_edge.sv - two-flop synchronizer with a one-cycle strobe on the press (falling) edge
module sc_button_sync_edge (
    input  logic SC_BTNSYNC_CLOCK_50,
    input  logic SC_BTNSYNC_RESET_InLow,
    input  logic SC_BTNSYNC_button_InLow,
    output logic SC_BTNSYNC_press_OutHigh
);

    logic buttonMeta;
    logic buttonSync;
    logic buttonPrev;

    // all flops release to 1 so a button held through reset still counts as one press
    always_ff @(posedge SC_BTNSYNC_CLOCK_50 or negedge SC_BTNSYNC_RESET_InLow) begin
        if (!SC_BTNSYNC_RESET_InLow) begin
            buttonMeta <= 1'b1;
            buttonSync <= 1'b1;
            buttonPrev <= 1'b1;
        end else begin
            buttonMeta <= SC_BTNSYNC_button_InLow;
            buttonSync <= buttonMeta;
            buttonPrev <= buttonSync;
        end
    end

    assign SC_BTNSYNC_press_OutHigh = buttonPrev & ~buttonSync;

endmodule

// File: rtl/sc_car_move_controller.sv
// rtl/sc_car_move_controller.sv - sequences clear/load/shift commands of the one-hot car position register
module sc_car_move_controller
    import sc_car_move_controller_pkg::*;
#(
    parameter int                   MOVE_COOLDOWN   = 12500000,
    parameter int                   CNT_WIDTH       = 24,
    parameter int                   POS_WIDTH       = 8,
    parameter logic [POS_WIDTH-1:0] POS_LEFT_LIMIT  = POS_WIDTH'(LANE_LEFT_LIMIT),
    parameter logic [POS_WIDTH-1:0] POS_RIGHT_LIMIT = POS_WIDTH'(LANE_RIGHT_LIMIT)
) (
    input  logic                    SC_CARCTRL_CLOCK_50,
    input  logic                    SC_CARCTRL_RESET_InLow,
    sc_car_move_controller_if.slave carBus
);

    logic startMeta;
    logic startSync;
    logic leftPress;
    logic rightPress;

    car_state_t           state;
    logic [1:0]           moveDir;
    logic                 limitHit;
    logic [CNT_WIDTH-1:0] cooldownCnt;

    always_ff @(posedge SC_CARCTRL_CLOCK_50 or negedge SC_CARCTRL_RESET_InLow) begin
        if (!SC_CARCTRL_RESET_InLow) begin
            startMeta <= 1'b1;
            startSync <= 1'b1;
        end else begin
            startMeta <= carBus.SC_CARCTRL_start_InLow;
            startSync <= startMeta;
        end
    end

    sc_button_sync_edge leftSync (
        .SC_BTNSYNC_CLOCK_50      (SC_CARCTRL_CLOCK_50),
        .SC_BTNSYNC_RESET_InLow   (SC_CARCTRL_RESET_InLow),
        .SC_BTNSYNC_button_InLow  (carBus.SC_CARCTRL_left_InLow),
        .SC_BTNSYNC_press_OutHigh (leftPress)
    );

    sc_button_sync_edge rightSync (
        .SC_BTNSYNC_CLOCK_50      (SC_CARCTRL_CLOCK_50),
        .SC_BTNSYNC_RESET_InLow   (SC_CARCTRL_RESET_InLow),
        .SC_BTNSYNC_button_InLow  (carBus.SC_CARCTRL_right_InLow),
        .SC_BTNSYNC_press_OutHigh (rightPress)
    );

    always_ff @(posedge SC_CARCTRL_CLOCK_50 or negedge SC_CARCTRL_RESET_InLow) begin
        if (!SC_CARCTRL_RESET_InLow) begin
            state       <= IDLE;
            moveDir     <= SHIFT_HOLD;
            limitHit    <= 1'b0;
            cooldownCnt <= '0;
        end else begin
            limitHit <= 1'b0;
            case (state)
                IDLE: begin
                    if (!startSync) state <= LOAD;
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    // simultaneous presses cancel each other; start is ignored here
                    if (carBus.SC_CARCTRL_crash_InHigh) begin
                        state <= CRASHED;
                    end else if (leftPress && !rightPress) begin
                        if (carBus.SC_CARCTRL_position_InBus == POS_LEFT_LIMIT) begin
                            limitHit <= 1'b1;
                        end else begin
                            moveDir <= SHIFT_LEFT;
                            state   <= MOVE;
                        end
                    end else if (rightPress && !leftPress) begin
                        if (carBus.SC_CARCTRL_position_InBus == POS_RIGHT_LIMIT) begin
                            limitHit <= 1'b1;
                        end else begin
                            moveDir <= SHIFT_RIGHT;
                            state   <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    if (carBus.SC_CARCTRL_crash_InHigh) begin
                        state <= CRASHED;
                    end else begin
                        state       <= COOLDOWN;
                        cooldownCnt <= CNT_WIDTH'(MOVE_COOLDOWN - 1);
                    end
                end
                COOLDOWN: begin
                    if (carBus.SC_CARCTRL_crash_InHigh) begin
                        state <= CRASHED;
                    end else if (cooldownCnt == '0) begin
                        state <= RUN;
                    end else begin
                        cooldownCnt <= cooldownCnt - 1'b1;
                    end
                end
                CRASHED: begin
                    if (!startSync) state <= LOAD;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign carBus.SC_CARCTRL_clear_OutLow  = (state != IDLE);
    assign carBus.SC_CARCTRL_load_OutLow   = (state != LOAD);
    assign carBus.SC_CARCTRL_shift_OutBus  = (state == MOVE) ? moveDir : SHIFT_HOLD;
    assign carBus.SC_CARCTRL_limit_OutHigh = limitHit;
    assign carBus.SC_CARCTRL_state_OutBus  = state;

endmodule

// File: tb/tb_sc_car_move_controller.sv
// tb/tb_sc_car_move_controller.sv - directed and random checks of the car move controller against a behavioural model
module tb_sc_car_move_controller;

    localparam int COOL = 4;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_MOVE = 3, M_COOL = 4, M_CRASH = 5;
    localparam logic [7:0] CENTRE = 8'b00010000;
    localparam logic [7:0] LEFT_LIM = 8'b01000000;
    localparam logic [7:0] RIGHT_LIM = 8'b00000010;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic bL = 1'b1, bR = 1'b1, bS = 1'b1, crash = 1'b0;
    logic [7:0] carPos = 8'h00;

    sc_car_move_controller_if bus ();

    assign bus.SC_CARCTRL_start_InLow    = bS;
    assign bus.SC_CARCTRL_left_InLow     = bL;
    assign bus.SC_CARCTRL_right_InLow    = bR;
    assign bus.SC_CARCTRL_crash_InHigh   = crash;
    assign bus.SC_CARCTRL_position_InBus = carPos;

    sc_car_move_controller #(
        .MOVE_COOLDOWN (COOL),
        .CNT_WIDTH     (24),
        .POS_WIDTH     (8)
    ) dut (
        .SC_CARCTRL_CLOCK_50    (clk),
        .SC_CARCTRL_RESET_InLow (rstN),
        .carBus                 (bus)
    );

    int nChecks = 0;
    int nErrors = 0;
    int cyc = 0;

    int mMode = M_IDLE;
    int mRemain = 0;
    logic [1:0] mDir = 2'b00;
    logic mLimit = 1'b0;
    logic [2:0] hL = 3'b111, hR = 3'b111;
    logic [1:0] hS = 2'b11;

    int cntShift, cntLimit, cntCool;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkOutputs();
        check("state", 32'(bus.SC_CARCTRL_state_OutBus), 32'(mMode));
        check("clear", 32'(bus.SC_CARCTRL_clear_OutLow), 32'(mMode != M_IDLE));
        check("load", 32'(bus.SC_CARCTRL_load_OutLow), 32'(mMode != M_LOAD));
        check("shift", 32'(bus.SC_CARCTRL_shift_OutBus), (mMode == M_MOVE) ? 32'(mDir) : 32'd0);
        check("limit", 32'(bus.SC_CARCTRL_limit_OutHigh), 32'(mLimit));
    endtask

    // one clock: a press counts 2 edges after it is first sampled low, start level 2 edges late
    task automatic cycle();
        logic pL, pR, sLow;
        int prevMode;
        logic [1:0] prevDir;
        logic [7:0] posSeen;
        pL = hL[2] & ~hL[1];
        pR = hR[2] & ~hR[1];
        sLow = ~hS[1];
        prevMode = mMode;
        prevDir = mDir;
        posSeen = carPos;
        @(posedge clk);
        cyc++;
        hL = {hL[1:0], bL};
        hR = {hR[1:0], bR};
        hS = {hS[0], bS};
        mLimit = 1'b0;
        case (mMode)
            M_IDLE:  if (sLow) mMode = M_LOAD;
            M_LOAD:  mMode = M_RUN;
            M_RUN: begin
                if (crash) mMode = M_CRASH;
                else if (pL && !pR) begin
                    if (posSeen == LEFT_LIM) mLimit = 1'b1;
                    else begin mDir = 2'b01; mMode = M_MOVE; end
                end else if (pR && !pL) begin
                    if (posSeen == RIGHT_LIM) mLimit = 1'b1;
                    else begin mDir = 2'b10; mMode = M_MOVE; end
                end
            end
            M_MOVE: begin
                if (crash) mMode = M_CRASH;
                else begin mMode = M_COOL; mRemain = COOL; end
            end
            M_COOL: begin
                if (crash) mMode = M_CRASH;
                else begin
                    mRemain--;
                    if (mRemain == 0) mMode = M_RUN;
                end
            end
            M_CRASH: if (sLow) mMode = M_LOAD;
            default: mMode = M_IDLE;
        endcase
        if (prevMode == M_IDLE) carPos = 8'h00;
        else if (prevMode == M_LOAD) carPos = CENTRE;
        else if (prevMode == M_MOVE) carPos = (prevDir == 2'b01) ? (carPos << 1) : (carPos >> 1);
        #1;
        checkOutputs();
    endtask

    task automatic holdReset();
        rstN = 1'b0;
        mMode = M_IDLE;
        mLimit = 1'b0;
        mRemain = 0;
        hL = 3'b111;
        hR = 3'b111;
        hS = 2'b11;
        carPos = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic pressAndCount(input bit useL, input bit useR, input int holdCyc, input int tailCyc);
        cntShift = 0;
        cntLimit = 0;
        cntCool = 0;
        if (useL) bL = 1'b0;
        if (useR) bR = 1'b0;
        for (int i = 0; i < holdCyc + tailCyc; i++) begin
            if (i == holdCyc) begin bL = 1'b1; bR = 1'b1; end
            cycle();
            if (bus.SC_CARCTRL_shift_OutBus !== 2'b00) cntShift++;
            if (bus.SC_CARCTRL_limit_OutHigh === 1'b1) cntLimit++;
            if (bus.SC_CARCTRL_state_OutBus === 3'd4) cntCool++;
        end
    endtask

    task automatic restart();
        crash = 1'b0;
        bS = 1'b0;
        repeat (3) cycle();
        bS = 1'b1;
        repeat (2) cycle();
        check("restart_run", 32'(bus.SC_CARCTRL_state_OutBus), 32'd2);
    endtask

    initial begin
        int loadLow;

        // reset state
        holdReset();
        checkOutputs();
        check("reset_cnt", 32'(dut.cooldownCnt), 32'd0);

        // start sequence
        loadLow = 0;
        bS = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) bS = 1'b1;
            cycle();
            if (bus.SC_CARCTRL_load_OutLow === 1'b0) loadLow++;
        end
        check("load_pulse_len", 32'(loadLow), 32'd1);
        check("run_after_start", 32'(bus.SC_CARCTRL_state_OutBus), 32'd2);

        // held left: one move, cooldown of COOL cycles
        pressAndCount(1, 0, 14, 4);
        check("held_shift_count", 32'(cntShift), 32'd1);
        check("cool_cycles", 32'(cntCool), 32'(COOL));

        // left limit
        pressAndCount(1, 0, 3, 8);
        pressAndCount(1, 0, 3, 8);
        check("left_limit_pulse", 32'(cntLimit), 32'd1);
        check("left_limit_shift", 32'(cntShift), 32'd0);

        // walk to right limit
        for (int i = 0; i < 5; i++) pressAndCount(0, 1, 3, 8);
        pressAndCount(0, 1, 3, 8);
        check("right_limit_pulse", 32'(cntLimit), 32'd1);
        check("right_limit_shift", 32'(cntShift), 32'd0);

        // simultaneous presses
        pressAndCount(1, 1, 3, 6);
        check("both_shift", 32'(cntShift), 32'd0);
        check("both_limit", 32'(cntLimit), 32'd0);

        // right press during cooldown is dropped
        bL = 1'b0;
        repeat (3) cycle();
        bL = 1'b1;
        cycle();
        check("in_cooldown", 32'(bus.SC_CARCTRL_state_OutBus), 32'd4);
        cntShift = 0;
        bR = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) bR = 1'b1;
            cycle();
            if (bus.SC_CARCTRL_shift_OutBus !== 2'b00) cntShift++;
        end
        check("cool_drop_shift", 32'(cntShift), 32'd0);

        // crash in MOVE
        bL = 1'b0;
        repeat (3) cycle();
        check("move_state", 32'(bus.SC_CARCTRL_state_OutBus), 32'd3);
        crash = 1'b1;
        bL = 1'b1;
        cycle();
        check("crash_move_state", 32'(bus.SC_CARCTRL_state_OutBus), 32'd5);
        check("crash_clear", 32'(bus.SC_CARCTRL_clear_OutLow), 32'd1);
        check("crash_load", 32'(bus.SC_CARCTRL_load_OutLow), 32'd1);
        check("crash_shift", 32'(bus.SC_CARCTRL_shift_OutBus), 32'd0);
        restart();

        // crash in COOLDOWN
        bL = 1'b0;
        repeat (4) cycle();
        bL = 1'b1;
        check("cool_before_crash", 32'(bus.SC_CARCTRL_state_OutBus), 32'd4);
        crash = 1'b1;
        cycle();
        check("crash_cool_state", 32'(bus.SC_CARCTRL_state_OutBus), 32'd5);
        restart();

        // crash in RUN
        crash = 1'b1;
        cycle();
        check("crash_run_state", 32'(bus.SC_CARCTRL_state_OutBus), 32'd5);
        restart();

        // asynchronous reset during COOLDOWN
        bL = 1'b0;
        repeat (5) cycle();
        bL = 1'b1;
        check("cool_before_reset", 32'(bus.SC_CARCTRL_state_OutBus), 32'd4);
        #2;
        rstN = 1'b0;
        #1;
        check("async_state", 32'(bus.SC_CARCTRL_state_OutBus), 32'd0);
        check("async_clear", 32'(bus.SC_CARCTRL_clear_OutLow), 32'd0);
        check("async_shift", 32'(bus.SC_CARCTRL_shift_OutBus), 32'd0);
        check("async_cnt", 32'(dut.cooldownCnt), 32'd0);
        holdReset();
        checkOutputs();
        restart();

        // random buttons, crash and start against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 4) == 0) bL = ~bL;
            if ($urandom_range(0, 4) == 0) bR = ~bR;
            bS = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
            crash = ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
